// File: rtl/vector_sequencer.sv
// -----------------------------------------------------------------------------
// vector_sequencer
//
// Walks the test-vector RAM and presents each word to the DUT stimulus path.
// For every vector it fetches the word, drives it, waits a fixed settle time,
// and then waits for the ADC response. When the response arrives it issues a
// one-cycle compare strobe to the analyzer. The vector list is replayed for
// the requested number of passes.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, abort           run control from the configuration parser
//   num_vectors            vectors per pass (0..2**ADDR_W), sampled on start
//   num_passes             passes per run (0 behaves as 1), sampled on start
//   mem_addr, mem_rd_en    vector RAM read request (data one cycle later)
//   mem_rd_data            vector RAM read data
//   stim_data, stim_valid  stimulus word to the DUT digital I/O
//   resp_ready             ADC response available
//   cmp_strobe, expected   compare pulse and the word to compare against
//   busy, done, aborted    run status; done/aborted are one-cycle pulses
//   timeout_cnt            vectors that timed out this run (saturating)
//   pass_index             current pass, 0-based
// -----------------------------------------------------------------------------
module vector_sequencer #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 8,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   num_vectors,
  input  logic [15:0]       num_passes,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] stim_data,
  output logic              stim_valid,
  input  logic              resp_ready,
  output logic              cmp_strobe,
  output logic [DATA_W-1:0] expected,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [15:0]       timeout_cnt,
  output logic [15:0]       pass_index
);

  // One counter serves both SETTLE and WAIT; size it for the larger interval.
  localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_LOAD    = 3'd2,
    S_SETTLE  = 3'd3,
    S_WAIT    = 3'd4,
    S_COMPARE = 3'd5,
    S_NEXT    = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W:0]     nvec_q, nvec_d;
  logic [15:0]         npass_q, npass_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_rd_en_q, mem_rd_en_d;
  logic [DATA_W-1:0]   stim_data_q, stim_data_d;
  logic                stim_valid_q, stim_valid_d;
  logic                cmp_strobe_q, cmp_strobe_d;
  logic [DATA_W-1:0]   expected_q, expected_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic [15:0]         timeout_cnt_q, timeout_cnt_d;
  logic [15:0]         pass_index_q, pass_index_d;
  logic                abort_run_s;
  logic [ADDR_W:0]     idx_plus1_s;
  logic [15:0]         pass_plus1_s;

  // Next-state and next-output computation for the sequencer FSM.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    nvec_d        = nvec_q;
    npass_d       = npass_q;
    cnt_d         = cnt_q;
    stim_data_d   = stim_data_q;
    expected_d    = expected_q;
    timeout_cnt_d = timeout_cnt_q;
    pass_index_d  = pass_index_q;

    abort_run_s  = abort && (state_q != S_IDLE);
    // Widened by one bit so the last index of a full-depth RAM cannot overflow.
    idx_plus1_s  = {1'b0, idx_q} + {{ADDR_W{1'b0}}, 1'b1};
    pass_plus1_s = pass_index_q + 16'd1;

    if (abort_run_s) begin
      // Abort wins over everything else: nothing else in the run advances.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            nvec_d        = num_vectors;
            npass_d       = (num_passes == 16'd0) ? 16'd1 : num_passes;
            idx_d         = {ADDR_W{1'b0}};
            timeout_cnt_d = 16'd0;
            pass_index_d  = 16'd0;
            state_d       = (num_vectors == {(ADDR_W+1){1'b0}}) ? S_DONE : S_FETCH;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_FETCH: begin
          state_d = S_LOAD;
        end
        S_LOAD: begin
          // RAM data requested in FETCH is valid now.
          stim_data_d = mem_rd_data;
          expected_d  = mem_rd_data;
          cnt_d       = {CNT_W{1'b0}};
          state_d     = S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = S_WAIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT: begin
          // A response arriving on the final wait cycle still counts.
          if (resp_ready) begin
            state_d = S_COMPARE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (timeout_cnt_q != 16'hFFFF) begin
              timeout_cnt_d = timeout_cnt_q + 16'd1;
            end else begin
              timeout_cnt_d = timeout_cnt_q;
            end
            state_d = S_NEXT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_COMPARE: begin
          state_d = S_NEXT;
        end
        S_NEXT: begin
          if (idx_plus1_s != nvec_q) begin
            idx_d   = idx_plus1_s[ADDR_W-1:0];
            state_d = S_FETCH;
          end else begin
            idx_d        = {ADDR_W{1'b0}};
            pass_index_d = pass_plus1_s;
            state_d      = (pass_plus1_s == npass_q) ? S_DONE : S_FETCH;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Outputs are registered, so they are decoded from the state being entered.
    mem_rd_en_d  = (state_d == S_FETCH);
    mem_addr_d   = (state_d == S_FETCH) ? idx_d : mem_addr_q;
    cmp_strobe_d = (state_d == S_COMPARE);
    done_d       = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
    aborted_d    = abort_run_s;

    // Stimulus becomes valid once the first word is loaded and stays valid
    // (tracking later words) until the run returns to IDLE.
    if (state_d == S_IDLE) begin
      stim_valid_d = 1'b0;
    end else if (state_q == S_LOAD) begin
      stim_valid_d = 1'b1;
    end else begin
      stim_valid_d = stim_valid_q;
    end
  end

  // State, run context and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= {ADDR_W{1'b0}};
      nvec_q        <= {(ADDR_W+1){1'b0}};
      npass_q       <= 16'd0;
      cnt_q         <= {CNT_W{1'b0}};
      mem_addr_q    <= {ADDR_W{1'b0}};
      mem_rd_en_q   <= 1'b0;
      stim_data_q   <= {DATA_W{1'b0}};
      stim_valid_q  <= 1'b0;
      cmp_strobe_q  <= 1'b0;
      expected_q    <= {DATA_W{1'b0}};
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      timeout_cnt_q <= 16'd0;
      pass_index_q  <= 16'd0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      nvec_q        <= nvec_d;
      npass_q       <= npass_d;
      cnt_q         <= cnt_d;
      mem_addr_q    <= mem_addr_d;
      mem_rd_en_q   <= mem_rd_en_d;
      stim_data_q   <= stim_data_d;
      stim_valid_q  <= stim_valid_d;
      cmp_strobe_q  <= cmp_strobe_d;
      expected_q    <= expected_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      timeout_cnt_q <= timeout_cnt_d;
      pass_index_q  <= pass_index_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign stim_data   = stim_data_q;
  assign stim_valid  = stim_valid_q;
  assign cmp_strobe  = cmp_strobe_q;
  assign expected    = expected_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign timeout_cnt = timeout_cnt_q;
  assign pass_index  = pass_index_q;

endmodule

// File: tb/tb_vector_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vector_sequencer
//
// Scoreboard bench for vector_sequencer. Expected (word, pass) pairs are
// queued when a run is started and popped on every compare strobe. A small
// RAM model answers reads with one cycle of latency.
// -----------------------------------------------------------------------------
module tb_vector_sequencer;

  localparam int ADDR_W      = 4;
  localparam int DATA_W      = 8;
  localparam int SETTLE_CYC  = 4;
  localparam int TIMEOUT_CYC = 8;
  localparam int DEPTH       = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [ADDR_W:0]   num_vectors;
  logic [15:0]       num_passes;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] stim_data;
  logic              stim_valid;
  logic              resp_ready;
  logic              cmp_strobe;
  logic [DATA_W-1:0] expected;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [15:0]       timeout_cnt;
  logic [15:0]       pass_index;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [15:0]       pass;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  ram [DEPTH];
  int          checks;
  int          errors;
  int          cyc;
  int          fetch_cyc;
  int          reads;
  int          strobes;
  int          done_cnt;
  int          ab_cnt;
  bit          lat_en;

  vector_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_vectors(num_vectors), .num_passes(num_passes),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .stim_data(stim_data), .stim_valid(stim_valid), .resp_ready(resp_ready),
    .cmp_strobe(cmp_strobe), .expected(expected), .busy(busy), .done(done),
    .aborted(aborted), .timeout_cnt(timeout_cnt), .pass_index(pass_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector RAM model, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_addr];
    cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitor: counts events and scores every compare strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd_en) begin
        reads++;
        fetch_cyc = cyc;
      end
      if (cmp_strobe) begin
        strobes++;
        if (lat_en) check_eq("strobe_latency", cyc - fetch_cyc, 3 + SETTLE_CYC);
        if (sb_q.size() == 0) begin
          check_eq("strobe_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_eq("expected", expected, e.data);
          check_eq("stim_data", stim_data, e.data);
          check_eq("pass_index_at_strobe", pass_index, e.pass);
        end
      end
      if (done) done_cnt++;
      if (aborted) ab_cnt++;
    end
  end

  // Latch run parameters, queue expectations and pulse start for one cycle.
  task automatic start_run(input int nv, input int np, input int push_n);
    int npe;
    npe = (np == 0) ? 1 : np;
    num_vectors = (ADDR_W+1)'(nv);
    num_passes  = 16'(np);
    for (int p = 0; p < npe; p++)
      for (int v = 0; v < nv; v++)
        if (p * nv + v < push_n) sb_q.push_back('{data: ram[v], pass: 16'(p)});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for done or aborted with a cycle budget; then one more cycle.
  task automatic wait_end(input string tag, input int budget);
    int n;
    n = 0;
    while (!(done || aborted) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_end_seen"}, (done || aborted) ? 1 : 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_fetch_of(input int addr, input int budget);
    int n;
    n = 0;
    while (!(mem_rd_en && mem_addr == ADDR_W'(addr)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("fetch_seen", (mem_rd_en && mem_addr == ADDR_W'(addr)) ? 1 : 0, 1);
  endtask

  initial begin
    int s0, d0, r0, a0, n;
    checks = 0; errors = 0; cyc = 0; fetch_cyc = 0;
    reads = 0; strobes = 0; done_cnt = 0; ab_cnt = 0; lat_en = 1'b0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; resp_ready = 1'b0;
    num_vectors = '0; num_passes = 16'd0;
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'(8'h80 + i * 3);
    ram[0] = 8'd11; ram[1] = 8'd22; ram[2] = 8'd33; ram[3] = 8'd44;
    repeat (2) @(negedge clk);

    // Reset state
    check_eq("rst_busy", busy, 0);
    check_eq("rst_outputs", {mem_rd_en, stim_valid, cmp_strobe, done, aborted}, 0);
    check_eq("rst_counts", {timeout_cnt, pass_index}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic run: 4 vectors, 1 pass, response always ready
    resp_ready = 1'b1; lat_en = 1'b1;
    start_run(4, 1, 4);
    check_eq("busy_during_run", busy, 1);
    wait_end("basic", 200);
    check_eq("basic_strobes", strobes, 4);
    check_eq("basic_done", done_cnt, 1);
    check_eq("basic_reads", reads, 4);
    check_eq("basic_sb_empty", sb_q.size(), 0);
    check_eq("basic_pass_index", pass_index, 1);
    check_eq("basic_timeouts", timeout_cnt, 0);
    check_eq("basic_idle", {busy, stim_valid}, 0);

    // Multi-pass run with a start pulse mid-run that must be ignored
    s0 = strobes; d0 = done_cnt;
    start_run(2, 3, 6);
    repeat (12) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_end("passes", 300);
    check_eq("passes_strobes", strobes - s0, 6);
    check_eq("passes_done", done_cnt - d0, 1);
    check_eq("passes_sb_empty", sb_q.size(), 0);
    check_eq("passes_pass_index", pass_index, 3);
    repeat (3) @(negedge clk);
    check_eq("passes_no_restart", busy, 0);

    // Timeout: response never arrives
    resp_ready = 1'b0; lat_en = 1'b0;
    s0 = strobes; d0 = done_cnt;
    start_run(3, 1, 0);
    wait_end("timeout", 300);
    check_eq("timeout_strobes", strobes - s0, 0);
    check_eq("timeout_cnt", timeout_cnt, 3);
    check_eq("timeout_done", done_cnt - d0, 1);

    // Abort during SETTLE of vector 1
    resp_ready = 1'b1; lat_en = 1'b1;
    s0 = strobes; d0 = done_cnt; a0 = ab_cnt;
    start_run(4, 1, 1);
    wait_fetch_of(1, 50);
    @(negedge clk);            // LOAD
    @(negedge clk);            // first SETTLE cycle
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_pulse", aborted, 1);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_stim_valid", stim_valid, 0);
    repeat (15) @(negedge clk);
    check_eq("abort_pulses", ab_cnt - a0, 1);
    check_eq("abort_no_done", done_cnt - d0, 0);
    check_eq("abort_strobes", strobes - s0, 1);
    check_eq("abort_sb_empty", sb_q.size(), 0);

    // Empty vector list: done shortly after start, no reads, no strobes
    s0 = strobes; d0 = done_cnt; r0 = reads;
    num_vectors = '0; num_passes = 16'd1;
    start = 1'b1; @(negedge clk); start = 1'b0;
    n = 1;
    while (!done && n < 2) begin
      @(negedge clk);
      n++;
    end
    check_eq("empty_done_latency", done ? 1 : 0, 1);
    @(negedge clk);
    check_eq("empty_reads", reads - r0, 0);
    check_eq("empty_strobes", strobes - s0, 0);
    check_eq("empty_done_cnt", done_cnt - d0, 1);
    check_eq("empty_busy", busy, 0);

    // Response pulse during SETTLE is ignored; later pulse in WAIT accepted
    resp_ready = 1'b0; lat_en = 1'b0;
    s0 = strobes; d0 = done_cnt;
    start_run(1, 1, 1);
    wait_fetch_of(0, 20);
    @(negedge clk);            // LOAD
    @(negedge clk);            // SETTLE cycle 1
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    repeat (5) @(negedge clk); // now inside WAIT
    check_eq("settle_pulse_ignored", strobes - s0, 0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    wait_end("settle", 50);
    check_eq("settle_strobes", strobes - s0, 1);
    check_eq("settle_timeouts", timeout_cnt, 0);
    check_eq("settle_done", done_cnt - d0, 1);

    // start and abort together in IDLE: nothing happens
    d0 = done_cnt; a0 = ab_cnt;
    num_vectors = (ADDR_W+1)'(2);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("start_abort_busy", busy, 0);
    check_eq("start_abort_pulses", (done_cnt - d0) + (ab_cnt - a0), 0);

    // Full-depth vector list
    resp_ready = 1'b1; lat_en = 1'b1;
    s0 = strobes; r0 = reads; d0 = done_cnt;
    start_run(DEPTH, 1, DEPTH);
    wait_end("full", 600);
    check_eq("full_strobes", strobes - s0, DEPTH);
    check_eq("full_reads", reads - r0, DEPTH);
    check_eq("full_done", done_cnt - d0, 1);
    check_eq("full_sb_empty", sb_q.size(), 0);

    // Asynchronous reset mid-run
    d0 = done_cnt; a0 = ab_cnt;
    start_run(4, 2, 0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_outputs", {stim_valid, mem_rd_en, cmp_strobe, stim_data}, 0);
    check_eq("arst_counts", {timeout_cnt, pass_index}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("arst_no_pulses", (done_cnt - d0) + (ab_cnt - a0), 0);
    check_eq("arst_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
